pipe_add3_2stage: RTL and testbench
===================================

// Module: pipe_add3_2stage
//
// PURPOSE
//   Two-stage pipelined adder that sums three WIDTH-bit operands modulo 2^WIDTH.
//   Stage 1 adds in0+in1 and registers the partial sum with a delayed copy of in2.
//   Stage 2 adds the registered partial sum to the delayed in2 and registers the total.
//   Used as a datapath building block wherever a fixed-latency 3-operand add is needed.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits; all arithmetic wraps modulo 2^WIDTH
//
// PORTS
//   clk    input   1      single clock; all state updates on rising edge
//   reset  input   1      asynchronous, active-low reset (0 = reset asserted)
//   in0    input   WIDTH  operand 0, sampled every cycle
//   in1    input   WIDTH  operand 1, sampled every cycle
//   in2    input   WIDTH  operand 2, sampled every cycle
//   out01  output  WIDTH  stage-1 register: in0+in1 from 1 cycle earlier
//   out    output  WIDTH  stage-2 register: in0+in1+in2 from 2 cycles earlier
//
// BEHAVIOUR
//   - State: sum01_q (WIDTH), in2_q (WIDTH), sum_q (WIDTH); no other state.
//   - Reset: while reset==0, all three registers clear to 0 immediately,
//     without waiting for clk; out01=0, out=0. Reset mid-stream discards all
//     in-flight data; first valid out01 one edge after release, out two edges.
//   - Each rising edge with reset==1:
//       sum01_q <= in0 + in1        (truncated to WIDTH)
//       in2_q   <= in2
//       sum_q   <= sum01_q + in2_q  (truncated to WIDTH)
//   - out01 = sum01_q; out = sum_q; both driven straight from registers,
//     no combinational input-to-output path.
//   - Latency: out01 = 1 cycle, out = 2 cycles. No handshake/stall; a new
//     operand set is accepted every cycle (throughput 1/cycle).
//   - Alignment: out01 and out in the same cycle belong to DIFFERENT input
//     sets (out01 = set N, out = set N-1).
//   - Arithmetic: unsigned modular; carries out of bit WIDTH-1 discarded,
//     no overflow flag. Signed two's-complement operands give correct
//     wrapped signed results (e.g. -1 + 0 + 0 = 0xFF).
//   - Inputs are not required to be stable beyond setup/hold of the edge.
//
// TESTING
//   - Reset: hold reset=0, apply in=(0x55,0x55,0x55) -> out01=0,out=0 async;
//     release, then edges 1 and 2 show out01=0xAA, then out=0xFF.
//   - Example stream (1,2,4),(2,3,4),(3,4,5) at cycles N..N+2 -> out01=3,5,7
//     at N+1..N+3; out=7,9,12 at N+2..N+4; then zeros after zero inputs.
//   - Overflow: (127,1,0)->out01=0x80,out=0x80; (64,64,64)->out01=0x80,
//     out=0xC0; (-64,-64,-64)->out01=0x80,out=0x40; (-128,-1,0)->out=0x7F.
//   - Two-operand paths: (0,-128,127)->out01=0x80,out=0xFF;
//     (-128,0,127)->out01=0x80,out=0xFF; (42,-13,0)->out=29.
//   - Reset mid-stream: drive nonzero sets, assert reset between edges ->
//     outputs 0 at once; after release zero inputs keep out01=out=0.
//   - Random: 20 back-to-back random triples checked each cycle against a
//     2-deep model of the stage equations; no bubbles between samples.

Source files
------------

// File: rtl/pipe_add3_2stage.sv
// Two-stage pipelined three-operand adder, wrapping modulo 2^WIDTH.
// Stage 1 forms in0+in1 and carries in2 forward; stage 2 adds them.
module pipe_add3_2stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out01,
    output logic [WIDTH-1:0] out
);

    typedef struct packed {
        logic [WIDTH-1:0] sum01;
        logic [WIDTH-1:0] in2;
    } s1_t;

    s1_t              s1_d;
    s1_t              s1_q;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    // Carries out of the top bit are dropped by the WIDTH-bit targets.
    always_comb begin
        s1_d.sum01 = in0 + in1;
        s1_d.in2   = in2;
        sum_d      = s1_q.sum01 + s1_q.in2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q  <= '0;
            sum_q <= '0;
        end else begin
            s1_q  <= s1_d;
            sum_q <= sum_d;
        end
    end

    assign out01 = s1_q.sum01;
    assign out   = sum_q;

endmodule

// File: tb/tb_pipe_add3_2stage.sv
// Directed and model-checked bench for the two-stage 3-operand adder.
module tb_pipe_add3_2stage;

    logic       clk;
    logic       reset;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] out01;
    logic [7:0] out;

    int n_pass;
    int n_total;

    logic [7:0] m01;
    logic [7:0] mi2;
    logic [7:0] msum;

    pipe_add3_2stage #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .out01 (out01),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input string tag,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c,
                        input logic [7:0] e01, input logic [7:0] eout);
        @(negedge clk);
        in0 = a;
        in1 = b;
        in2 = c;
        @(posedge clk);
        #1;
        chk({tag, ".out01"}, out01, e01);
        chk({tag, ".out"}, out, eout);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b0;
        in0     = 8'h55;
        in1     = 8'h55;
        in2     = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold.out01", out01, 8'h00);
        chk("rst_hold.out", out, 8'h00);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_e1.out01", out01, 8'hAA);
        chk("rel_e1.out", out, 8'h00);

        step("stream0", 8'd1, 8'd2, 8'd4, 8'd3, 8'hFF);
        step("stream1", 8'd2, 8'd3, 8'd4, 8'd5, 8'd7);
        step("stream2", 8'd3, 8'd4, 8'd5, 8'd7, 8'd9);
        step("stream3", 8'd0, 8'd0, 8'd0, 8'd0, 8'd12);
        step("stream4", 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

        step("ovf127", 8'd127, 8'd1, 8'd0, 8'h80, 8'h00);
        step("ovf64", 8'd64, 8'd64, 8'd64, 8'h80, 8'h80);
        step("ovfm64", 8'hC0, 8'hC0, 8'hC0, 8'h80, 8'hC0);
        step("ovfm128", 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h40);
        step("two_b", 8'h00, 8'h80, 8'h7F, 8'h80, 8'h7F);
        step("two_a", 8'h80, 8'h00, 8'h7F, 8'h80, 8'hFF);
        step("s42m13", 8'd42, 8'hF3, 8'h00, 8'd29, 8'hFF);
        step("flush", 8'h00, 8'h00, 8'h00, 8'h00, 8'd29);

        step("mid0", 8'h10, 8'h20, 8'h30, 8'h30, 8'h00);
        step("mid1", 8'h11, 8'h22, 8'h33, 8'h33, 8'h60);
        reset = 1'b0;
        #1;
        chk("mid_rst.out01", out01, 8'h00);
        chk("mid_rst.out", out, 8'h00);
        @(negedge clk);
        in0   = 8'h00;
        in1   = 8'h00;
        in2   = 8'h00;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst1.out01", out01, 8'h00);
        chk("post_rst1.out", out, 8'h00);
        step("post_rst2", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);

        m01  = 8'h00;
        mi2  = 8'h00;
        msum = 8'h00;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            logic [7:0] c;
            a    = 8'($urandom_range(0, 255));
            b    = 8'($urandom_range(0, 255));
            c    = 8'($urandom_range(0, 255));
            msum = m01 + mi2;
            m01  = a + b;
            mi2  = c;
            step($sformatf("rand%0d", i), a, b, c, m01, msum);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
